// File: rtl/ws2811_pkg.sv
// ws2811_pkg: shared definitions for the WS2811 frame path.
//   state_t          frame sequencer states
//   BYTES_PER_PIXEL  G,R,B bytes per pixel
//   DEFAULT_*        default frame geometry and latch timing
//   cnt_width()      counter width for a given number of counts (minimum 1)
package ws2811_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_LATCH
  } state_t;

  localparam int unsigned BYTES_PER_PIXEL      = 3;
  localparam int unsigned DEFAULT_NUM_PIXELS   = 16;
  localparam int unsigned DEFAULT_ADDR_W       = 8;
  localparam int unsigned DEFAULT_LATCH_CYCLES = 600;  // >= 50 us at 12 MHz

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2811_latch_timer.sv
// ws2811_latch_timer: latch-gap down-counter.
//   clk, rst  clock, asynchronous active-high reset
//   load      loads LATCH_CYCLES-1 (takes priority over en)
//   en        decrements while the count is non-zero
//   count     current count
//   done      count is zero (the current cycle is the last of the gap)
module ws2811_latch_timer
  import ws2811_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  localparam int unsigned CNT_W = cnt_width(LATCH_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATCH_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer: walks pixel RAM (G,R,B per pixel) and hands bytes to the
// WS2811 serializer over valid/ready, then holds the latch gap and pulses frame_done.
//   CLKIN, RESET  clock, asynchronous active-high reset
//   start         frame request, sampled only in IDLE
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse in the last latch-gap cycle
//   rd_en/rd_addr pixel RAM read strobe and byte address; rd_data valid 1 cycle later
//   byte_data/byte_valid/byte_ready  byte handshake to the serializer
//   latch         high for the whole latch gap
// Build option: WS2811_AUTO_REFRESH_EN -- the end of the latch gap restarts the frame
// at address 0 instead of returning to IDLE.
module ws2811_frame_sequencer
  import ws2811_pkg::*;
#(
  parameter int unsigned NUM_PIXELS   = DEFAULT_NUM_PIXELS,
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic              CLKIN,
  input  logic              RESET,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              latch
);

  localparam int unsigned       CNT_W    = cnt_width(LATCH_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BYTES_PER_PIXEL * NUM_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              last_byte;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_done;
  logic [CNT_W-1:0]  tmr_count;

  assign last_byte = (idx == LAST_IDX);
  assign tmr_load  = (state == ST_PRESENT) && byte_ready && last_byte;
  assign tmr_en    = (state == ST_LATCH);

  ws2811_latch_timer #(
    .LATCH_CYCLES(LATCH_CYCLES)
  ) u_latch_timer (
    .clk  (CLKIN),
    .rst  (RESET),
    .load (tmr_load),
    .en   (tmr_en),
    .count(tmr_count),
    .done (tmr_done)
  );

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      latch      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FETCH;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= idx;
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT;
          rd_en <= 1'b0;
        end
        ST_WAIT: begin
          state      <= ST_PRESENT;
          byte_data  <= rd_data;
          byte_valid <= 1'b1;
        end
        ST_PRESENT: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            if (last_byte) begin
              state      <= ST_LATCH;
              latch      <= 1'b1;
              // frame_done is registered, so it is raised one edge ahead of the
              // last latch cycle; a one-cycle gap makes that the entry edge.
              frame_done <= (LATCH_CYCLES == 1);
            end else begin
              state   <= ST_FETCH;
              idx     <= idx + 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= idx + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          if (tmr_done) begin
            latch <= 1'b0;
            idx   <= '0;
`ifdef WS2811_AUTO_REFRESH_EN
            state   <= ST_FETCH;
            rd_en   <= 1'b1;
            rd_addr <= '0;
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            frame_done <= (tmr_count == CNT_W'(1));
          end
        end
        default: begin
          state      <= ST_IDLE;
          idx        <= '0;
          busy       <= 1'b0;
          rd_en      <= 1'b0;
          byte_valid <= 1'b0;
          latch      <= 1'b0;
        end
      endcase
    end
  end

endmodule
